// File: rtl/pid_pwm_stage.sv
// Output stage of the PID loop: issues the PID sample strobe, clamps the PID result
// into a PWM duty that is double-buffered at period boundaries, and trips a watchdog.
module pid_pwm_stage #(
  parameter int CNT_W      = 12,
  parameter int SAMPLE_DIV = 4,
  parameter int TIMEOUT    = 1023
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [CNT_W-1:0] i_period,
  input  logic [CNT_W-1:0] i_duty_max,
  input  logic [15:0]      i_un,
  input  logic             i_un_valid,
  output logic             o_sample_clk,
  output logic             o_pwm,
  output logic [CNT_W-1:0] o_duty,
  output logic             o_fault
);

  localparam int IDX_W = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
  localparam int WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SAMPLE_DIV - 1);
  localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TIMEOUT);

  // Saturate the unsigned PID result to the duty ceiling before truncating.
  function automatic logic [CNT_W-1:0] clamp_duty(input logic [15:0] un,
                                                  input logic [CNT_W-1:0] dmax);
    if (un > 16'(dmax)) return dmax;
    else return un[CNT_W-1:0];
  endfunction

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] per_q;
  logic [CNT_W-1:0] duty_act;
  logic [CNT_W-1:0] duty_pend;
  logic             pend;
  logic             awaiting;
  logic [WD_W-1:0]  wd;
  logic [IDX_W-1:0] idx;

  logic             period_end;
  logic [IDX_W-1:0] idx_next;
  logic             rise;
  logic             capture;
  logic             timeout;

  assign period_end = (cnt == per_q);
  assign idx_next   = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
  assign rise       = period_end && (idx_next == '0);
  assign capture    = i_un_valid && awaiting && !o_fault;
  // A valid arriving in the expiry cycle is served instead of faulting.
  assign timeout    = awaiting && (wd == WD_LIMIT) && !capture;
  assign o_duty     = duty_act;

  // Period counter and sample strobe; i_period is only taken at a boundary.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt          <= '0;
      per_q        <= '0;
      idx          <= '0;
      o_sample_clk <= 1'b0;
    end else if (period_end) begin
      cnt          <= '0;
      per_q        <= i_period;
      idx          <= idx_next;
      o_sample_clk <= (idx_next == '0);
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) o_pwm <= 1'b0;
    else       o_pwm <= (cnt < duty_act);
  end

  // Pending duty is applied first so a same-cycle capture lands in the next period.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      duty_act  <= '0;
      duty_pend <= '0;
      pend      <= 1'b0;
    end else begin
      if (period_end && pend) begin
        duty_act <= o_fault ? '0 : duty_pend;
        pend     <= 1'b0;
      end
      if (capture) begin
        duty_pend <= clamp_duty(i_un, i_duty_max);
        pend      <= 1'b1;
      end else if (timeout) begin
        duty_pend <= '0;
        pend      <= 1'b1;
      end
    end
  end

  // Watchdog: a new sample edge always restarts the wait.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      awaiting <= 1'b0;
      wd       <= '0;
      o_fault  <= 1'b0;
    end else begin
      if (capture) begin
        awaiting <= 1'b0;
      end else if (timeout) begin
        awaiting <= 1'b0;
        o_fault  <= 1'b1;
      end else if (awaiting) begin
        wd <= wd + WD_W'(1);
      end
      if (rise) begin
        awaiting <= 1'b1;
        wd       <= '0;
      end
    end
  end

endmodule
